mixer_sequencer: RTL

Frame-synchronous audio mixer and scheduler sitting between the sound channels (pulse, triangle, …) and the single shared `pwm` modulator. On each PWM cycle-end strobe it snapshots every channel output and mute bit, then sums the unmuted channels sequentially, one channel per clock, through a single adder. It publishes the result as a new compare value with a one-cycle valid strobe, so the modulator only changes duty cycle on a period boundary.

---
 rtl/mixer_pkg.sv | 23 ++
 rtl/mixer_clamp.sv | 23 ++
 rtl/mixer_sequencer.sv | 98 +++++++++
 3 files changed

// File: rtl/mixer_pkg.sv
// Shared types and width helpers for the mixer sequencer.
package mixer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    PUBLISH = 2'd2
  } mix_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Wide enough that summing every channel at full scale never overflows.
  function automatic int acc_width(input int in_w, input int out_w, input int n);
    return ((in_w > out_w) ? in_w : out_w) + clog2(n);
  endfunction

endpackage

// File: rtl/mixer_clamp.sv
// Reduces the wide accumulator to the compare width and flags overflow.
// Build option: MIXER_SATURATE_EN saturates instead of wrapping.
module mixer_clamp #(
  parameter int ACC_W     = 11,
  parameter int OUT_WIDTH = 9
) (
  input  logic [ACC_W-1:0]     acc,
  output logic [OUT_WIDTH-1:0] value,
  output logic                 clip
);

  logic [ACC_W-1:0] max_v;

  assign max_v = ACC_W'({OUT_WIDTH{1'b1}});
  assign clip  = acc > max_v;

`ifdef MIXER_SATURATE_EN
  assign value = clip ? {OUT_WIDTH{1'b1}} : acc[OUT_WIDTH-1:0];
`else
  assign value = acc[OUT_WIDTH-1:0];
`endif

endmodule

// File: rtl/mixer_sequencer.sv
// Frame-synchronous mixer: snapshots channels on a PWM cycle-end strobe and sums
// them one per clock. Build option MIXER_SATURATE_EN (see mixer_clamp).
module mixer_sequencer
  import mixer_pkg::*;
#(
  parameter int NUM_CHANNELS = 3,
  parameter int IN_WIDTH     = 9,
  parameter int OUT_WIDTH    = 9
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_CHANNELS*IN_WIDTH-1:0] i_channels,
  input  logic [NUM_CHANNELS-1:0]       i_mute,
  input  logic                          i_cycle_end,
  output logic [OUT_WIDTH-1:0]          o_compare,
  output logic                          o_compare_valid,
  output logic                          o_busy,
  output logic                          o_clip,
  output logic                          o_missed
);

  localparam int ACC_W = acc_width(IN_WIDTH, OUT_WIDTH, NUM_CHANNELS);
  localparam int IDX_W = (clog2(NUM_CHANNELS) > 0) ? clog2(NUM_CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

  mix_state_e                            state;
  logic [NUM_CHANNELS-1:0][IN_WIDTH-1:0] snap;
  logic [NUM_CHANNELS-1:0]               snap_mute;
  logic [ACC_W-1:0]                      acc;
  logic [ACC_W-1:0]                      addend;
  logic [IDX_W-1:0]                      idx;
  logic [OUT_WIDTH-1:0]                  clamp_val;
  logic                                  clamp_clip;

  always_comb begin
    addend = '0;
    if (!snap_mute[idx]) addend = ACC_W'(snap[idx]);
  end

  mixer_clamp #(
    .ACC_W     (ACC_W),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_clamp (
    .acc   (acc),
    .value (clamp_val),
    .clip  (clamp_clip)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      snap            <= '0;
      snap_mute       <= '0;
      acc             <= '0;
      idx             <= '0;
      o_compare       <= '0;
      o_compare_valid <= 1'b0;
      o_busy          <= 1'b0;
      o_clip          <= 1'b0;
      o_missed        <= 1'b0;
    end else begin
      o_compare_valid <= 1'b0;
      o_clip          <= 1'b0;
      o_missed        <= 1'b0;
      case (state)
        IDLE: begin
          if (i_cycle_end) begin
            snap      <= i_channels;
            snap_mute <= i_mute;
            acc       <= '0;
            idx       <= '0;
            state     <= ACCUM;
            o_busy    <= 1'b1;
          end
        end
        ACCUM: begin
          acc      <= acc + addend;
          o_missed <= i_cycle_end;
          if (idx == LAST_IDX) state <= PUBLISH;
          else                 idx   <= idx + IDX_W'(1);
        end
        PUBLISH: begin
          o_compare       <= clamp_val;
          o_compare_valid <= 1'b1;
          o_clip          <= clamp_clip;
          o_missed        <= i_cycle_end;
          state           <= IDLE;
          o_busy          <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
